// File: rtl/adiabatic_pclk_ctrl_pkg.sv
// Shared types for the adiabatic power-clock controller.
// Rail count, FSM states, per-rail phases, counter sizing.
package adiabatic_pkg;

  localparam int NUM_PC = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PH_RAMP_UP,
    PH_HOLD,
    PH_RAMP_DOWN,
    PH_WAIT
  } pc_phase_t;

  // Sub-phase counter width, never below one bit.
  function automatic int sub_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adiabatic_pclk_ctrl_if.sv
// Run-control and rail-driver bundle of the power-clock controller.
// master: core side (drives run/step); slave: controller.
interface adiabatic_pclk_ctrl_if
  import adiabatic_pkg::*;
;
  logic              run;
  logic              step;
  logic [NUM_PC-1:0] ramp_up;
  logic [NUM_PC-1:0] hold;
  logic [NUM_PC-1:0] ramp_down;
  logic              busy;
  logic              period_done;
  logic [1:0]        phase_idx;

  modport master (
    output run, step,
    input  ramp_up, hold, ramp_down,
    input  busy, period_done, phase_idx
  );

  modport slave (
    input  run, step,
    output ramp_up, hold, ramp_down,
    output busy, period_done, phase_idx
  );

endinterface

// File: rtl/adiabatic_pclk_ctrl_rail_decode.sv
// One power-clock rail: local phase (ph-K) mod 4 plus fill/drain gating.
// Ports: i_ph, i_state, i_first in; o_ramp_up/o_hold/o_ramp_down out.
module pc_rail_decode
  import adiabatic_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [1:0]  i_ph,
  input  ctrl_state_t i_state,
  input  logic        i_first,
  output logic        o_ramp_up,
  output logic        o_hold,
  output logic        o_ramp_down
);

  localparam logic [1:0] KB = 2'(K);
  // Bit p set when ph=p may charge this rail (ph >= K);
  // the complement is where a drain still owns it (K > ph).
  localparam logic [3:0] FILL_OK = 4'(4'hF << K);
  localparam logic [3:0] DRAIN_OK = ~FILL_OK;

  pc_phase_t w_local;
  logic      w_en;

  assign w_local = pc_phase_t'(i_ph - KB);

  always_comb begin
    w_en = 1'b0;
    unique case (i_state)
      RUN:     w_en = !i_first || FILL_OK[i_ph];
      DRAIN:   w_en = DRAIN_OK[i_ph];
      default: w_en = 1'b0;
    endcase
  end

  assign o_ramp_up   = w_en && (w_local == PH_RAMP_UP);
  assign o_hold      = w_en && (w_local == PH_HOLD);
  assign o_ramp_down = w_en && (w_local == PH_RAMP_DOWN);

endmodule

// File: rtl/adiabatic_pclk_ctrl.sv
// 4-phase trapezoidal power-clock sequencer with fill and drain.
// Ports: clk, rst (async high), bus (slave: run/step in, rails/status out).
module adiabatic_pclk_ctrl
  import adiabatic_pkg::*;
#(
  parameter int PHASE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adiabatic_pclk_ctrl_if.slave bus
);

  localparam int SW = sub_width(PHASE_CYCLES);
  localparam logic [SW-1:0] SUB_LAST = SW'(PHASE_CYCLES - 1);

  ctrl_state_t r_state;
  logic [1:0]  r_ph;
  logic [SW-1:0] r_sub;
  logic        r_first;
  logic        r_step_mode;

  logic              w_last;
  logic [NUM_PC-1:0] w_ru;
  logic [NUM_PC-1:0] w_hd;
  logic [NUM_PC-1:0] w_rd;

  assign w_last = (r_sub == SUB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ph        <= '0;
      r_sub       <= '0;
      r_first     <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        if (w_last) begin
          r_sub <= '0;
          r_ph  <= r_ph + 2'd1;
        end else begin
          r_sub <= r_sub + 1'b1;
        end
      end
      unique case (r_state)
        IDLE: begin
          if (bus.run || bus.step) begin
            r_state     <= RUN;
            r_ph        <= '0;
            r_sub       <= '0;
            r_first     <= 1'b1;
            r_step_mode <= ~bus.run;
          end
        end
        RUN: begin
          // run seen mid-step upgrades to continuous
          if (bus.run) r_step_mode <= 1'b0;
          if (w_last && r_ph == 2'd3) begin
            r_first <= 1'b0;
            // ph wraps to 0 naturally on entry to DRAIN
            if (!bus.run || r_step_mode)
              r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last && r_ph == 2'd2) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_sub   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PC; k++) begin : g_rail
    pc_rail_decode #(
      .K(k)
    ) u_dec (
      .i_ph        (r_ph),
      .i_state     (r_state),
      .i_first     (r_first),
      .o_ramp_up   (w_ru[k]),
      .o_hold      (w_hd[k]),
      .o_ramp_down (w_rd[k])
    );
  end

  assign bus.ramp_up     = w_ru;
  assign bus.hold        = w_hd;
  assign bus.ramp_down   = w_rd;
  assign bus.busy        = (r_state != IDLE);
  assign bus.period_done = (r_state == RUN) && (r_ph == 2'd3) && w_last;
  assign bus.phase_idx   = r_ph;

endmodule

// File: tb/tb_adiabatic_pclk_ctrl.sv
// Scoreboard bench for adiabatic_pclk_ctrl (PHASE_CYCLES 4 and 1).
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_adiabatic_pclk_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adiabatic_pclk_ctrl_if bus4 ();
  adiabatic_pclk_ctrl_if bus1 ();

  adiabatic_pclk_ctrl #(.PHASE_CYCLES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  adiabatic_pclk_ctrl #(.PHASE_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  typedef struct {
    int          cyc;
    bit          dut;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // obs layout: [15:12] ramp_up, [11:8] hold, [7:4] ramp_down,
  // [3] busy, [2] period_done, [1:0] phase_idx
  localparam logic [15:0] ALL  = 16'hFFFF;
  localparam logic [15:0] RAIL = 16'hFFF0;
  localparam logic [15:0] BUSY = 16'h0008;
  localparam logic [15:0] PD   = 16'h0004;
  localparam logic [15:0] PH   = 16'h0003;

  function automatic logic [15:0] RU(int k);
    return 16'(16'h1000 << k);
  endfunction
  function automatic logic [15:0] HD(int k);
    return 16'(16'h0100 << k);
  endfunction
  function automatic logic [15:0] RD(int k);
    return 16'(16'h0010 << k);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [15:0] o4, o1, o;
    o4 = {bus4.ramp_up, bus4.hold, bus4.ramp_down,
          bus4.busy, bus4.period_done, bus4.phase_idx};
    o1 = {bus1.ramp_up, bus1.hold, bus1.ramp_down,
          bus1.busy, bus1.period_done, bus1.phase_idx};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        o = sb[i].dut ? o1 : o4;
        n_cmp++;
        if ((o & sb[i].mask) !== sb[i].val) begin
          n_err++;
          $display("FAIL %s c%0d dut%0d: got %h want %h",
                   sb[i].name, sb[i].cyc - base + 1,
                   sb[i].dut, o & sb[i].mask, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic want(string nm, bit d, logic [15:0] m,
                      logic [15:0] v, int c0, int c1);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc  = base + c - 1;
      e.dut  = d;
      e.mask = m;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic start();
    @(negedge clk);
    base = cyc + 1;
  endtask

  task automatic goto(int c);
    for (int i = 0; i < 1000 && cyc != base + c - 1; i++)
      @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.run = 1'b0; bus4.step = 1'b0;
    bus1.run = 1'b0; bus1.step = 1'b0;
    @(posedge clk);

    start();
    want("rst4", 0, ALL, 16'h0, 1, 2);
    want("rst1", 1, ALL, 16'h0, 1, 2);
    goto(3); rst = 1'b0;
    want("idle4", 0, ALL, 16'h0, 4, 5);
    goto(6);

    start();
    bus4.step = 1'b1;
    want("s_ru0", 0, RU(0), RU(0), 1, 4);
    want("s_hd0", 0, HD(0), HD(0), 5, 8);
    want("s_rd0", 0, RD(0), RD(0), 9, 12);
    want("s_ru0w", 0, RU(0), 16'h0, 13, 16);
    want("s_ru3n", 0, RU(3), 16'h0, 1, 12);
    want("s_ru3", 0, RU(3), RU(3), 13, 16);
    want("s_hd3", 0, HD(3), HD(3), 17, 20);
    want("s_rd3", 0, RD(3), RD(3), 21, 24);
    want("s_rd2", 0, RD(2), RD(2), 17, 20);
    want("s_pd0", 0, PD, 16'h0, 1, 15);
    want("s_pd", 0, PD, PD, 16, 16);
    want("s_pd1", 0, PD, 16'h0, 17, 28);
    want("s_busy", 0, BUSY, BUSY, 1, 28);
    want("s_end", 0, ALL, 16'h0, 29, 32);
    goto(1); bus4.step = 1'b0;
    goto(34);
    n_cmp++;
    if (bus4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL d_step: got busy=%b want 0", bus4.busy);
    end

    start();
    bus4.run = 1'b1;
    want("r_pd16", 0, PD, PD, 16, 16);
    want("r_pd32", 0, PD, PD, 32, 32);
    want("r_pd48", 0, PD, PD, 48, 48);
    want("r_pdn", 0, PD, 16'h0, 15, 15);
    want("r_pdn", 0, PD, 16'h0, 17, 31);
    want("r_pdn", 0, PD, 16'h0, 33, 47);
    want("r_pdn", 0, PD, 16'h0, 49, 60);
    want("r_hd2", 0, HD(2), HD(2), 29, 32);
    want("r_hd3p2", 0, HD(3), HD(3), 17, 20);
    want("r_rd1", 0, RD(1), RD(1), 45, 48);
    want("r_rd2", 0, RD(2), RD(2), 49, 52);
    want("r_hd3", 0, HD(3), HD(3), 49, 52);
    want("r_rd3", 0, RD(3), RD(3), 53, 56);
    want("r_ph0", 0, PH, 16'd0, 49, 49);
    want("r_ph1", 0, PH, 16'd1, 53, 53);
    want("r_ph2", 0, PH, 16'd2, 57, 57);
    want("r_quiet", 0, RAIL, 16'h0, 57, 60);
    want("r_busy", 0, BUSY, BUSY, 1, 60);
    want("r_end", 0, ALL, 16'h0, 61, 64);
    goto(40); bus4.run = 1'b0;
    goto(66);
    n_cmp++;
    if (bus4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL d_run: got busy=%b want 0", bus4.busy);
    end

    start();
    bus4.run = 1'b1;
    want("f_none", 0,
         HD(1) | RD(1) | HD(2) | RD(2) | HD(3) | RD(3),
         16'h0, 1, 4);
    want("f_ru1n", 0, RU(1), 16'h0, 4, 4);
    want("f_ru1", 0, RU(1), RU(1), 5, 5);
    want("f_ru2n", 0, RU(2), 16'h0, 8, 8);
    want("f_ru2", 0, RU(2), RU(2), 9, 9);
    want("f_busy", 0, BUSY, BUSY, 28, 28);
    want("f_idle", 0, BUSY, 16'h0, 29, 29);
    goto(2); bus4.run = 1'b0;
    goto(32);
    n_cmp++;
    if (bus4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL d_fill: got busy=%b want 0", bus4.busy);
    end

    start();
    bus4.run = 1'b1;
    want("a_busy", 0, BUSY, BUSY, 1, 9);
    want("a_ph", 0, PH, 16'd2, 9, 9);
    want("a_rst", 0, ALL, 16'h0, 10, 12);
    want("a_idle", 0, ALL, 16'h0, 13, 16);
    goto(9);
    @(posedge clk);
    #2 rst = 1'b1;
    goto(12);
    n_cmp++;
    if ({bus4.ramp_up, bus4.hold, bus4.ramp_down} !== 12'h0) begin
      n_err++;
      $display("FAIL d_rst: got rails=%h want 0",
               {bus4.ramp_up, bus4.hold, bus4.ramp_down});
    end
    bus4.run = 1'b0;
    rst = 1'b0;
    goto(18);

    start();
    bus4.step = 1'b1;
    want("i_busy", 0, BUSY, BUSY, 1, 28);
    want("i_pd", 0, PD, PD, 16, 16);
    want("i_pdn", 0, PD, 16'h0, 17, 28);
    want("i_idle", 0, ALL, 16'h0, 29, 29);
    want("i_re", 0, RU(0), RU(0), 30, 33);
    want("i_repd", 0, PD, PD, 45, 45);
    want("i_rebusy", 0, BUSY, BUSY, 30, 57);
    want("i_end", 0, ALL, 16'h0, 58, 60);
    goto(1); bus4.step = 1'b0;
    goto(3); bus4.step = 1'b1;
    goto(4); bus4.step = 1'b0;
    goto(18); bus4.run = 1'b1;
    goto(20); bus4.step = 1'b1;
    goto(21); bus4.step = 1'b0;
    goto(31); bus4.run = 1'b0;
    goto(62);
    n_cmp++;
    if (bus4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL d_ign: got busy=%b want 0", bus4.busy);
    end

    start();
    bus1.step = 1'b1;
    want("p_ru0", 1, RU(0), RU(0), 1, 1);
    want("p_hd0", 1, HD(0), HD(0), 2, 2);
    want("p_rd0", 1, RD(0), RD(0), 3, 3);
    want("p_ru3", 1, RU(3), RU(3), 4, 4);
    want("p_hd3", 1, HD(3), HD(3), 5, 5);
    want("p_rd3", 1, RD(3), RD(3), 6, 6);
    want("p_pdn", 1, PD, 16'h0, 1, 3);
    want("p_pd", 1, PD, PD, 4, 4);
    want("p_pdn", 1, PD, 16'h0, 5, 7);
    want("p_ph3", 1, PH, 16'd3, 4, 4);
    want("p_ph1", 1, PH, 16'd1, 6, 6);
    want("p_busy", 1, BUSY, BUSY, 1, 7);
    want("p_end", 1, ALL, 16'h0, 8, 9);
    goto(1); bus1.step = 1'b0;
    goto(12);
    n_cmp++;
    if ({bus1.ramp_up, bus1.hold, bus1.ramp_down, bus1.busy,
         bus1.period_done, bus1.phase_idx} !== 16'h0) begin
      n_err++;
      $display("FAIL d_p1: got nonzero want 0");
    end

    foreach (sb[i]) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unchecked want checked", sb[i].name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adiabatic_pclk_ctrl.md
Name: adiabatic_pclk_ctrl

Overview:
- Sequences the 4-phase trapezoidal power clocks that drive the adiabatic gate stages.
- Drives four power-clock rails, each offset by one phase. Each rail cycles RAMP_UP, HOLD, RAMP_DOWN, WAIT, with every phase lasting PHASE_CYCLES clocks.
- Fills the rail pipeline cleanly on start and drains it on stop, so that no rail is left charged and none ramps down before it has been charged.
- Sits between the core run control and the analog rail drivers.

Parameters:
- PHASE_CYCLES, 4, clocks per phase; must be >= 1. The sub-phase counter width is $clog2(PHASE_CYCLES) with a minimum of 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- run  input  1  level request for continuous operation
- step  input  1  single-cycle pulse requesting exactly one power-clock period
- ramp_up  output  4  per-rail charge-ramp enable
- hold  output  4  per-rail hold-at-VDD enable
- ramp_down  output  4  per-rail recovery-ramp enable
- busy  output  1  high in RUN or DRAIN
- period_done  output  1  one-cycle pulse on the last clock of phase 3
- phase_idx  output  2  global phase counter ph

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset applies immediately:
  - state=IDLE, ph=0, sub=0, first=0, step_mode=0.
  - All outputs are 0.
  - Reset mid-operation drops the rails without recovery, and this is accepted.
- Counters, while in RUN or DRAIN:
  - sub increments every clock.
  - At sub==PHASE_CYCLES-1: sub returns to 0 and ph increments modulo 4.
- Local phase of rail k is (ph-k) mod 4: 0=RAMP_UP, 1=HOLD, 2=RAMP_DOWN, 3=WAIT.
  - The matching output bit is high; in WAIT all three bits are low.
  - At most one of ramp_up[k], hold[k], ramp_down[k] is high in any cycle.
- Gating, applied per rail on top of the local-phase decode:
  - IDLE: all rails are 0.
  - RUN with first=1 (the first period after start): rail k is active only when ph >= k. This is the fill.
  - DRAIN: rail k is active only when k > ph. New charges are suppressed; charged rails still complete HOLD and RAMP_DOWN.
- FSM transitions:
  - IDLE -> RUN when run=1 or step=1 is sampled. ph=0, sub=0, first=1, and step_mode=~run are loaded.
  - Latency is one clock: ramp_up[0] is high in the first RUN cycle.
  - RUN, at the end of ph 3 (period_done cycle): first is cleared.
    - If run=1 and step_mode=0, stay in RUN.
    - Otherwise go to DRAIN with ph=0.
  - RUN, when run falls mid-period: the current period completes, then DRAIN.
  - DRAIN -> IDLE at the end of ph 2, after three phases. busy falls in the IDLE cycle.
- Ignored inputs:
  - step is ignored while busy.
  - run rising during DRAIN is ignored until IDLE. If run is still high in IDLE, the next start follows one clock later.
  - run rising during a step period converts it to continuous operation: step_mode is cleared when run=1 is sampled in RUN.
  - run and step high together in IDLE means continuous operation (step_mode=0).
- Timing for a single step: busy lasts 7*PHASE_CYCLES clocks (4 RUN phases + 3 DRAIN phases). period_done pulses exactly once.
- Every rail charged by the controller completes its RAMP_DOWN before the controller returns to IDLE.

Decomposition:
- Package adiabatic_pkg:
  - localparam NUM_PC=4
  - typedef enum ctrl_state_t {IDLE, RUN, DRAIN}
  - typedef enum logic[1:0] pc_phase_t {PH_RAMP_UP, PH_HOLD, PH_RAMP_DOWN, PH_WAIT}
- Sub-module pc_rail_decode:
  - Inputs: ph, rail index k (parameter), state, first.
  - Outputs: ramp_up, hold, ramp_down for one rail.
  - Instantiated NUM_PC times in a generate loop.
- The top level holds the FSM, counters and step_mode.

Test Plan (PHASE_CYCLES=4; cycle 1 = first RUN cycle):
- step pulse in IDLE:
  - ramp_up[0] in cycles 1-4, hold[0] 5-8, ramp_down[0] 9-12.
  - ramp_up[3] in 13-16, ramp_down[3] 21-24.
  - period_done at cycle 16; busy for 28 cycles; all outputs 0 afterwards.
- run held high for 3 periods, then dropped at cycle 40:
  - period_done at 16, 32 and 48.
  - In period 2, rail 2 is in HOLD at ph 3 (cycles 29-32).
  - DRAIN runs cycles 49-60; rails 1-3 complete RAMP_DOWN; busy=0 at cycle 61.
- Fill check, run=1 at cycle 1:
  - hold[1], ramp_down[1], hold[2], ramp_down[2], hold[3] and ramp_down[3] stay 0 through cycle 4.
  - ramp_up[1] rises at cycle 5.
- rst asserted at cycle 10 during RUN: all outputs are 0 in the same cycle (asynchronously); state=IDLE; no period_done.
- step pulses at cycles 3 and 20, and run high during DRAIN at cycle 18: all are ignored; busy=0 at cycle 29; if run is still high, restart at cycle 30.
- PHASE_CYCLES=1, step: the phase sequence advances every clock; busy lasts 7 clocks; period_done at cycle 4.
